// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and width helpers for the PISO transmit sequencer
package piso_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bits needed to count n distinct values, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// rtl/tx_shift_reg.sv - N-bit parallel-load, right-shift, zero-fill register
// Clear wins over load, load wins over shift.
module tx_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         clr_in,
  input  logic         load_in,
  input  logic         shift_in,
  input  logic [N-1:0] d_in,
  output logic         bit0_out
);

  logic [N-1:0] sr_q;

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      sr_q <= '0;
    end else if (clr_in) begin
      sr_q <= '0;
    end else if (load_in) begin
      sr_q <= d_in;
    end else if (shift_in) begin
      sr_q <= {1'b0, sr_q[N-1:1]};
    end
  end

  assign bit0_out = sr_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - transmit sequencer: word handshake, LSB-first shift-out, inter-frame gap, abort
// The enum value GAP is shadowed by the parameter of the same name, so the state is written piso_pkg::GAP.
module piso_tx_ctrl #(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic [N-1:0] d_in,
  input  logic         d_valid_in,
  output logic         d_ready_out,
  input  logic         abort_in,
  output logic         ser_out,
  output logic         ser_valid_out,
  output logic         first_out,
  output logic         last_out,
  output logic         busy_out
);

  import piso_pkg::*;

  localparam int              BW       = cnt_w(N);
  localparam int              GW       = cnt_w(GAP + 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(N - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          last_bit;
  logic          gap_done;
  logic          accept;
  logic          sr_bit0;
  logic          sr_clr;
  logic          sr_load;
  logic          sr_shift;

  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST);
  assign gap_done = (gap_cnt_q == GAP_LAST);

  // Ready only in IDLE, or on the final bit when frames may run back-to-back.
  assign d_ready_out = reset_al_in && !abort_in &&
                       ((state_q == IDLE) || ((GAP == 0) && last_bit));
  assign accept      = d_valid_in && d_ready_out;

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort_in) begin
          state_d = IDLE;
        end else if (last_bit) begin
          if (accept)       state_d = SHIFT;
          else if (GAP > 0) state_d = piso_pkg::GAP;
          else              state_d = IDLE;
        end
      end
      piso_pkg::GAP: begin
        if (abort_in || gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_clr        = abort_in;
    sr_load       = accept;
    sr_shift      = (state_q == SHIFT);
    ser_valid_out = (state_q == SHIFT);
    ser_out       = (state_q == SHIFT) && sr_bit0;
    first_out     = (state_q == SHIFT) && (bit_cnt_q == '0);
    last_out      = last_bit;
    busy_out      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else if (abort_in) begin
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (accept || last_bit) begin
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if ((state_q == piso_pkg::GAP) && !gap_done) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end else begin
        gap_cnt_q <= '0;
      end
    end
  end

  tx_shift_reg #(
    .N(N)
  ) u_shift_reg (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .clr_in      (sr_clr),
    .load_in     (sr_load),
    .shift_in    (sr_shift),
    .d_in        (d_in),
    .bit0_out    (sr_bit0)
  );

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb/tb_piso_tx_ctrl.sv - scoreboard bench for piso_tx_ctrl in three parameter configurations
module tb_piso_tx_ctrl;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] a_d = '0;
  logic       a_valid = 1'b0;
  logic       a_abort = 1'b0;
  logic       a_ready, a_ser, a_sv, a_first, a_last, a_busy;

  logic [3:0] b_d = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_ser, b_sv, b_first, b_last, b_busy;

  logic [7:0] c_d = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_ser, c_sv, c_first, c_last, c_busy;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  piso_tx_ctrl #(.N(4), .GAP(1)) u_a (
    .clk(clk), .reset_al_in(rst_n), .d_in(a_d), .d_valid_in(a_valid), .d_ready_out(a_ready),
    .abort_in(a_abort), .ser_out(a_ser), .ser_valid_out(a_sv), .first_out(a_first),
    .last_out(a_last), .busy_out(a_busy)
  );

  piso_tx_ctrl #(.N(4), .GAP(0)) u_b (
    .clk(clk), .reset_al_in(rst_n), .d_in(b_d), .d_valid_in(b_valid), .d_ready_out(b_ready),
    .abort_in(1'b0), .ser_out(b_ser), .ser_valid_out(b_sv), .first_out(b_first),
    .last_out(b_last), .busy_out(b_busy)
  );

  piso_tx_ctrl #(.N(8), .GAP(2)) u_c (
    .clk(clk), .reset_al_in(rst_n), .d_in(c_d), .d_valid_in(c_valid), .d_ready_out(c_ready),
    .abort_in(1'b0), .ser_out(c_ser), .ser_valid_out(c_sv), .first_out(c_first),
    .last_out(c_last), .busy_out(c_busy)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [3:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) qa.push_back(exp_t'({w[i], (i == 0), (i == 3)}));
  endtask

  task automatic push_b(input logic [3:0] w);
    for (int i = 0; i < 4; i++) qb.push_back(exp_t'({w[i], (i == 0), (i == 3)}));
  endtask

  task automatic push_c(input logic [7:0] w);
    for (int i = 0; i < 8; i++) qc.push_back(exp_t'({w[i], (i == 0), (i == 7)}));
  endtask

  always @(negedge clk) begin
    if (a_sv) begin
      if (qa.size() == 0) begin
        check("a_extra_bit", 1'b1, 1'b0);
      end else begin
        ea = qa.pop_front();
        check("a_ser", a_ser, ea.b);
        check("a_first", a_first, ea.f);
        check("a_last", a_last, ea.l);
      end
    end
  end

  always @(negedge clk) begin
    if (b_sv) begin
      if (qb.size() == 0) begin
        check("b_extra_bit", 1'b1, 1'b0);
      end else begin
        eb = qb.pop_front();
        check("b_ser", b_ser, eb.b);
        check("b_first", b_first, eb.f);
        check("b_last", b_last, eb.l);
      end
    end
  end

  always @(negedge clk) begin
    if (c_sv) begin
      if (qc.size() == 0) begin
        check("c_extra_bit", 1'b1, 1'b0);
      end else begin
        ec = qc.pop_front();
        check("c_ser", c_ser, ec.b);
        check("c_first", c_first, ec.f);
        check("c_last", c_last, ec.l);
      end
    end
  end

  initial begin : stim
    int rem;

    #2 rst_n = 1'b0;
    #1;
    check("rst_a_sv", a_sv, 1'b0);
    check("rst_a_ser", a_ser, 1'b0);
    check("rst_a_first", a_first, 1'b0);
    check("rst_a_last", a_last, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_a_rdy", a_ready, 1'b1);
    check("rel_a_busy", a_busy, 1'b0);
    check("rel_b_rdy", b_ready, 1'b1);
    check("rel_c_rdy", c_ready, 1'b1);

    // Single frame 1011 with one gap cycle.
    @(negedge clk);
    a_d = 4'b1011; a_valid = 1'b1; push_a(4'b1011, 4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin a_valid = 1'b0; a_d = 4'h0; end
      check("t1_sv", a_sv, (c <= 4));
      check("t1_rdy", a_ready, (c == 6));
      check("t1_busy", a_busy, (c <= 5));
      if (c == 5) begin
        check("t1_gap_ser", a_ser, 1'b0);
        check("t1_gap_first", a_first, 1'b0);
        check("t1_gap_last", a_last, 1'b0);
      end
    end

    // Valid raised mid-frame is held off until the first IDLE cycle.
    a_d = 4'h3; a_valid = 1'b1; push_a(4'h3, 4);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    a_d = 4'hC; a_valid = 1'b1; push_a(4'hC, 4);
    check("t2_rdy_shift", a_ready, 1'b0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      check("t2_rdy", a_ready, (c == 6));
    end
    @(negedge clk);
    a_valid = 1'b0; a_d = 4'hF;
    check("t2_first", a_first, 1'b1);
    check("t2_sv", a_sv, 1'b1);
    repeat (5) @(negedge clk);
    check("t2_idle_rdy", a_ready, 1'b1);

    // Abort in IDLE blocks acceptance.
    a_abort = 1'b1; a_valid = 1'b1; a_d = 4'h7;
    #1;
    check("t3_abort_rdy", a_ready, 1'b0);
    @(negedge clk);
    check("t3_no_accept", a_busy, 1'b0);
    a_abort = 1'b0; a_valid = 1'b0;

    // Abort of frame F after two bits, then a clean frame 9.
    @(negedge clk);
    a_d = 4'hF; a_valid = 1'b1; push_a(4'hF, 2);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    #1;
    check("t4_sv", a_sv, 1'b0);
    check("t4_busy", a_busy, 1'b0);
    check("t4_rdy", a_ready, 1'b1);
    a_d = 4'h9; a_valid = 1'b1; push_a(4'h9, 4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) a_valid = 1'b0;
      check("t4_sv2", a_sv, (c <= 4));
      check("t4_rdy2", a_ready, (c == 6));
    end

    // GAP=0: A then 5 with valid held, no bubble.
    b_d = 4'hA; b_valid = 1'b1; push_b(4'hA);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin b_d = 4'h5; push_b(4'h5); end
      if (c == 5) begin b_valid = 1'b0; b_d = 4'h0; end
      check("b_sv", b_sv, (c <= 8));
      if (c <= 4) check("b_rdy", b_ready, (c == 4));
      if (c == 9) begin
        check("b_end_busy", b_busy, 1'b0);
        check("b_end_rdy", b_ready, 1'b1);
      end
    end

    // N=8, GAP=2 with random valid against a cycle-count model.
    rem = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (rem > 0) rem--;
      check("c_rdy", c_ready, (rem == 0));
      check("c_sv", c_sv, (rem > 2));
      check("c_busy", c_busy, (rem > 0));
      c_valid = ($urandom_range(0, 2) != 0);
      c_d = 8'($urandom);
      if (c_valid && rem == 0) begin
        push_c(c_d);
        rem = 11;
      end
    end
    c_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Reset between edges mid-frame of 0110 after two bits.
    a_d = 4'h6; a_valid = 1'b1; push_a(4'h6, 2);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_sv", a_sv, 1'b0);
    check("t5_ser", a_ser, 1'b0);
    check("t5_first", a_first, 1'b0);
    check("t5_last", a_last, 1'b0);
    check("t5_busy", a_busy, 1'b0);
    check("t5_rdy", a_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_rel_busy", a_busy, 1'b0);
    check("t5_rel_rdy", a_ready, 1'b1);
    repeat (8) @(negedge clk);

    check("qa_empty", (qa.size() == 0), 1'b1);
    check("qb_empty", (qb.size() == 0), 1'b1);
    check("qc_empty", (qc.size() == 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
